// File: rtl/aes_inv_key_schedule.sv
// ---------------------------------------------------------------------------
// aes_inv_key_schedule
//
// Iterative AES-128 inverse key expander. It takes the round-10 key and walks
// the key schedule backwards, presenting round keys 10, 9, ..., 0 on a
// valid/ready stream with one key per accepted beat.
//
// Optional feature macro: AES_INV_KEY_STORE_EN
//   When defined, an 11 x 128-bit store keeps every emitted round key and
//   rd_key reads store[rd_idx] combinationally. When undefined, no store is
//   built and rd_key is tied to 0.
//
// Handshake: a beat transfers on a rising edge where round_valid and
// round_ready are both high. round_valid never drops and round_key/round_idx
// never change while a beat waits for round_ready.
//
// Ports
//   clk          : clock, rising edge
//   rst          : asynchronous active-high reset
//   start        : begin expansion (sampled only when idle)
//   key_in[127:0]: round-10 key, w0 = [127:96] ... w3 = [31:0]
//   round_key    : current round key
//   round_idx    : round number of round_key (10 down to 0)
//   round_valid  : round_key/round_idx valid
//   round_ready  : consumer accepts the beat
//   busy         : expansion in progress
//   done         : one-cycle pulse after the round-0 beat is accepted
//   rd_idx       : store read index (store build only)
//   rd_key       : store read data (0 without the store)
//
// The FSM state is held in state_q (type state_e) so checkers can bind to it.
// ---------------------------------------------------------------------------
module aes_inv_key_schedule #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         round_valid,
  input  logic         round_ready,
  output logic         busy,
  output logic         done,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  // Forward AES S-box, entry n holds S(n).
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_e;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Rcon for the step that leaves round i; indices outside 1..10 give 0.
  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  state_e        state_q, state_d;
  logic [127:0]  round_key_q, round_key_d;
  logic [3:0]    round_idx_q, round_idx_d;
  logic          round_valid_q, round_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          accept;
  logic [31:0]   w0, w1, w2, w3;
  logic [31:0]   w0_prev, w1_prev, w2_prev, w3_prev;
  logic [31:0]   rot_w;
  logic [31:0]   sub_w;
  logic [127:0]  prev_key;

  assign accept = round_valid_q & round_ready;

  // Inverse key step: undo the XOR chain first, then recover w0 using the
  // recovered w3 of the previous round (which is what the forward step fed
  // into RotWord/SubWord).
  always_comb begin
    w0      = round_key_q[127:96];
    w1      = round_key_q[95:64];
    w2      = round_key_q[63:32];
    w3      = round_key_q[31:0];
    w3_prev = w3 ^ w2;
    w2_prev = w2 ^ w1;
    w1_prev = w1 ^ w0;
    rot_w   = {w3_prev[23:0], w3_prev[31:24]};
    sub_w   = {sbox(rot_w[31:24]), sbox(rot_w[23:16]),
               sbox(rot_w[15:8]),  sbox(rot_w[7:0])};
    w0_prev = w0 ^ sub_w ^ {rcon(round_idx_q), 24'h0};
    prev_key = {w0_prev, w1_prev, w2_prev, w3_prev};
  end

  always_comb begin
    state_d       = state_q;
    round_key_d   = round_key_q;
    round_idx_d   = round_idx_q;
    round_valid_d = round_valid_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          round_key_d   = key_in;
          round_idx_d   = LAST_IDX;
          round_valid_d = 1'b1;
          busy_d        = 1'b1;
          state_d       = S_EMIT;
        end
      end
      S_EMIT: begin
        if (accept) begin
          if (round_idx_q != 4'd0) begin
            round_key_d = prev_key;
            round_idx_d = round_idx_q - 4'd1;
          end else begin
            // Key and index hold their last values; only the flags drop.
            round_valid_d = 1'b0;
            busy_d        = 1'b0;
            done_d        = 1'b1;
            state_d       = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      round_key_q   <= '0;
      round_idx_q   <= '0;
      round_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      round_key_q   <= round_key_d;
      round_idx_q   <= round_idx_d;
      round_valid_q <= round_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign round_key   = round_key_q;
  assign round_idx   = round_idx_q;
  assign round_valid = round_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;

`ifdef AES_INV_KEY_STORE_EN
  // Entry i captures the round-i key as its beat is accepted. A new
  // expansion simply overwrites entries as it goes.
  logic [127:0] store_q [0:10];
  logic [127:0] store_d [0:10];

  always_comb begin
    for (int i = 0; i <= 10; i++) begin
      store_d[i] = store_q[i];
    end
    if (accept && (round_idx_q <= 4'd10)) begin
      store_d[round_idx_q] = round_key_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= 10; i++) begin
        store_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i <= 10; i++) begin
        store_q[i] <= store_d[i];
      end
    end
  end

  assign rd_key = (rd_idx <= 4'd10) ? store_q[rd_idx] : '0;
`else
  logic unused_rd_idx;
  assign unused_rd_idx = ^rd_idx;
  assign rd_key        = '0;
`endif

endmodule

// File: doc/aes_inv_key_schedule.md
# aes_inv_key_schedule

Iterative AES-128 inverse key expander for the decryption datapath. It takes the final (round-10) round key and walks the key schedule backwards, emitting round keys 10 down to 0, one per accepted beat, over a valid/ready stream. It is the reverse counterpart of the combinational forward `KeyGeneration` step. The inverse cipher core consumes its output in the order it needs: 10 first, 0 last.

## Interface
- `NUM_ROUNDS`, 10: number of rounds; the block is fixed to 10 for AES-128.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request to begin expansion; sampled only in IDLE.
- `key_in` input 128: round-10 key; w0 = bits [127:96], w3 = bits [31:0]; captured on the accepted `start`.
- `round_key` output 128: current round key.
- `round_idx` output 4: round number of `round_key`, 10 down to 0.
- `round_valid` output 1: `round_key` and `round_idx` are valid.
- `round_ready` input 1: consumer accepts the beat when high together with `round_valid`.
- `busy` output 1: an expansion is in progress.
- `done` output 1: one-cycle pulse on acceptance of the round-0 beat.
- `rd_idx` input 4: stored-key read index (only with `AES_INV_KEY_STORE_EN`).
- `rd_key` output 128: stored key at `rd_idx` (only with `AES_INV_KEY_STORE_EN`).

## Operation
- FSM states:
  - IDLE: on `start` = 1, capture `key_in`, set `round_idx` = 10, go to EMIT.
  - EMIT: `round_valid` = 1.
    - On accept with `round_idx` > 0: load the previous round key, decrement `round_idx`, stay in EMIT.
    - On accept with `round_idx` = 0: pulse `done`, go to IDLE.
- Inverse step, current key w0..w3 at round i, producing the key for round i-1:
  - w3' = w3 ^ w2
  - w2' = w2 ^ w1
  - w1' = w1 ^ w0
  - w0' = w0 ^ SubWord(RotWord(w3')) ^ {Rcon[i], 24'h0}
- RotWord rotates left by one byte. SubWord applies the forward AES S-box to each of the 4 bytes, as 4 combinational table instances.
- Rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36. Select by `round_idx`; out-of-range indices give 00.
- All arithmetic is GF(2) XOR on 32-bit words; there is no carry or width growth.
- While `round_valid` = 1 and `round_ready` = 0, hold `round_key` and `round_idx` stable.
- `start` is ignored while `busy` = 1. There is no abort; a new key needs `rst` or completion.
- Reset mid-operation: return immediately to IDLE and zero all outputs. Any partial expansion is discarded.

## Timing
- Reset values:
  - `round_key` = 0, `round_idx` = 0
  - `round_valid`, `busy`, `done` = 0
  - `rd_key` = 0, all store entries = 0
- `start` high in IDLE at edge N gives:
  - `round_valid` = 1, `busy` = 1 and `round_key` = `key_in` with `round_idx` = 10 from cycle N+1.
- Each accepting edge advances one round. With `round_ready` held at 1, round 0 is presented in cycle N+11.
- On the edge accepting round 0:
  - `done` = 1 for the following single cycle.
  - `busy` and `round_valid` go low in that same cycle.
- Earliest next `start` is sampled in the cycle `done` is high, which is the IDLE state.
- Throughput: 11 beats in 11 cycles with no stalls. Latency from `start` to first beat is 1 cycle.

## Configuration
- `AES_INV_KEY_STORE_EN` defined:
  - Builds an 11 x 128-bit register store. Entry i is written when the beat with `round_idx` = i is accepted.
  - `rd_key` = store[`rd_idx`] combinationally; it reads 0 for `rd_idx` > 10.
  - The store is cleared on `rst`. It is not cleared on `start`; entries are overwritten as the new expansion proceeds.
- `AES_INV_KEY_STORE_EN` not defined:
  - No store is built.
  - `rd_idx` is ignored and `rd_key` is tied to 0.

## Test plan
- FIPS-197 C.1: `key_in` = 13111d7fe3944a17f307a78b4d2b30c5 with `round_ready` = 1 gives:
  - 11 beats, indices 10 down to 0.
  - Last beat 000102030405060708090a0b0c0d0e0f.
  - `done` one cycle after the last beat is accepted.
- FIPS-197 A.1: `key_in` = d014f9a8c9ee2589e13f0cc8b6630ca6 gives:
  - `round_idx` 9 beat = ac7766f319fadc2128d12941575c006e.
  - `round_idx` 0 beat = 2b7e151628aed2a6abf7158809cf4f3c.
- Backpressure: hold `round_ready` = 0 for 5 cycles at `round_idx` = 6 -> key and index are stable for those 5 cycles, and the remaining sequence is unchanged versus the no-stall run.
- Ignored start: pulse `start` with a different `key_in` while `busy` -> the output sequence is unaffected and only one `done` is seen.
- Reset mid-op: assert `rst` at `round_idx` = 4 -> all outputs are 0 immediately. A later `start` then yields a full, correct 11-beat sequence.
- With `AES_INV_KEY_STORE_EN`, after C.1 completes:
  - `rd_idx` = 0 -> 000102030405060708090a0b0c0d0e0f
  - `rd_idx` = 10 -> 13111d7fe3944a17f307a78b4d2b30c5
  - `rd_idx` = 12 -> 0
